shift_unit_seq: RTL and testbench
=================================

// Module: shift_unit_seq
// PURPOSE
//   Sequential shift unit of the multicycle CPU datapath. Consumes the 5-bit shift amount chosen by the
//   shift-amount mux (shamt field, constant 16 for LUI, register-sourced amounts) plus a 32-bit operand,
//   and performs SLL/SRL/SRA/ROR/ROL one bit per cycle under a start/done handshake from the control FSM.
//   Result is held on data_out until the next accepted command and feeds the register-file write mux.
// PARAMETERS
//   DATA_W   32  operand/result width
//   SHAMT_W  5   shift-amount width (max shift = 2**SHAMT_W-1)
// PORTS
//   clk       in   1        single clock, all state updates on rising edge
//   reset_n   in   1        synchronous, active-low reset
//   start     in   1        command strobe; sampled only in IDLE or DONE
//   op        in   3        000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROR, 110 ROL, 111 reserved
//   data_in   in   DATA_W   operand, captured on accepted start
//   shamt     in   SHAMT_W  shift amount, captured on accepted start
//   busy      out  1        high while in SHIFT
//   done      out  1        one-cycle pulse: data_out valid and final
//   data_out  out  DATA_W   working/result register
// BEHAVIOUR
//   - Reset (reset_n=0 at edge): state=IDLE, data_out=0, count=0, busy=0, done=0. Dominates start.
//   - FSM IDLE -> SHIFT -> DONE -> IDLE. busy=(state==SHIFT); done=(state==DONE).
//   - Accept: start=1 at edge t while state IDLE or DONE. op captured, data_in -> data_out, shamt -> count.
//     op NOP/111: not accepted (no state change, data_out held).
//     op LOAD or shamt==0: -> DONE at edge t (data_out = data_in unshifted).
//     else: -> SHIFT at edge t.
//   - SHIFT: each edge applies one 1-bit step of captured op to data_out, count -= 1; step with count==1
//     moves to DONE. Shifts occur at edges t+1..t+shamt; done high in cycle after edge t+shamt.
//     Latency start-to-done = shamt+1 cycles (1 for shamt 0 / LOAD).
//   - Step rules: SLL zero-fill LSB; SRL zero-fill MSB; SRA replicate bit DATA_W-1; ROR bit0 -> MSB;
//     ROL MSB -> bit0. No flags produced.
//   - start while SHIFT: ignored, operation continues unaffected; no queueing.
//   - start in DONE: accepted (back-to-back); done still pulses exactly one cycle for the prior command.
//   - DONE with no start: -> IDLE; data_out holds result indefinitely.
//   - Reset mid-SHIFT: abort, outputs per reset, no done pulse.
// CONFIGURATION
//   FAST_SHIFT_EN defined: single-cycle barrel shifter; every accepted non-NOP command goes straight
//     to DONE at edge t with full result; SHIFT state unreachable, busy constant 0, latency 1 for any shamt.
//   FAST_SHIFT_EN undefined: iterative behaviour above (default; small area).
// STRUCTURE
//   - Package cpu_shift_pkg: op encoding localparams (SH_NOP..SH_ROL), FSM state typedef
//     (ST_IDLE, ST_SHIFT, ST_DONE), DATA_W/SHAMT_W defaults.
//   - Sub-module shift_step: combinational 1-bit step (op, data) -> data; reused by iterative path,
//     chained/replaced by barrel logic under FAST_SHIFT_EN.
// TESTING
//   - SLL data_in=0x00000001 shamt=4 -> SHIFT 4 cycles, done 5 cycles after start, data_out=0x00000010.
//   - LUI path: SLL data_in=0x0000ABCD shamt=16 -> data_out=0xABCD0000, done after 17 cycles.
//   - SRA data_in=0x80000000 shamt=31 -> 0xFFFFFFFF; SRL same operand -> 0x00000001.
//   - ROR 0x00000001 shamt=1 -> 0x80000000; ROL 0x80000001 shamt=4 -> 0x00000018; shamt=0 -> done in 1 cycle, unchanged.
//   - start (SLL 0xFFFFFFFF, shamt 8) asserted during busy of SRL 0xF0000000 shamt 3 -> ignored,
//     result 0x1E000000, exactly one done.
//   - reset_n low mid-SHIFT -> next cycle IDLE, data_out=0, busy=0, no done; FAST_SHIFT_EN build: all above in 1 cycle.

Source files
------------

// File: rtl/cpu_shift_pkg.sv
// Shared definitions for the sequential shift unit: op encoding, FSM states, width defaults.
package cpu_shift_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;
    localparam logic [2:0] SH_ROL  = 3'b110;
    localparam logic [2:0] SH_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

    // NOP and the reserved code never start a command
    function automatic logic op_accepts(input logic [2:0] op);
        return (op != SH_NOP) && (op != SH_RSVD);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; non-shift ops pass data through.
module shift_step
    import cpu_shift_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // one-bit move in the direction selected by op
    always_comb begin
        q = d;
        case (op)
            SH_SLL:  q = {d[DATA_W-2:0], 1'b0};
            SH_SRL:  q = {1'b0, d[DATA_W-1:1]};
            SH_SRA:  q = {d[DATA_W-1], d[DATA_W-1:1]};
            SH_ROR:  q = {d[0], d[DATA_W-1:1]};
            SH_ROL:  q = {d[DATA_W-2:0], d[DATA_W-1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shift unit: start/done handshake, one bit per cycle by default.
// Define FAST_SHIFT_EN to replace the iterative path with a single-cycle barrel shifter.
module shift_unit_seq
    import cpu_shift_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  data_out
);

    shift_state_t       state;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] count;
    logic [DATA_W-1:0]  load_val;
    logic               direct_done;

`ifdef FAST_SHIFT_EN
    logic [2*DATA_W-1:0] rot;

    // full barrel result computed from the live inputs at accept time
    always_comb begin
        rot      = '0;
        load_val = data_in;
        case (op)
            SH_SLL: load_val = data_in << shamt;
            SH_SRL: load_val = data_in >> shamt;
            SH_SRA: load_val = DATA_W'($signed(data_in) >>> shamt);
            SH_ROR: begin
                rot      = {data_in, data_in} >> shamt;
                load_val = rot[DATA_W-1:0];
            end
            SH_ROL: begin
                rot      = {data_in, data_in} << shamt;
                load_val = rot[2*DATA_W-1:DATA_W];
            end
            default: load_val = data_in;
        endcase
    end

    assign direct_done = 1'b1;
`else
    logic [DATA_W-1:0] step_q;

    shift_step #(.DATA_W(DATA_W)) u_step (
        .op (op_q),
        .d  (data_out),
        .q  (step_q)
    );

    assign load_val    = data_in;
    assign direct_done = (op == SH_LOAD) || (shamt == '0);
`endif

    // control FSM plus working register; reset dominates everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            op_q     <= SH_NOP;
            count    <= '0;
            data_out <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && op_accepts(op)) begin
                        op_q     <= op;
                        count    <= shamt;
                        data_out <= load_val;
                        state    <= direct_done ? ST_DONE : ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`ifndef FAST_SHIFT_EN
                ST_SHIFT: begin
                    data_out <= step_q;
                    count    <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1))
                        state <= ST_DONE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_shift_unit_seq;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] last_res;

    shift_unit_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // reference: whole shift by plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input int s);
        logic [63:0] w;
        w = {d, d};
        case (o)
            OP_SLL: return d << s;
            OP_SRL: return d >> s;
            OP_SRA: return 32'($signed(d) >>> s);
            OP_ROR: return w[s +: 32];
            OP_ROL: return w[(32 - s) +: 32];
            default: return d;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input int s);
`ifdef FAST_SHIFT_EN
        return 1;
`else
        return (o == OP_LOAD || s == 0) ? 1 : s + 1;
`endif
    endfunction

    // monitor: every done pulse must match the oldest outstanding command
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", data_out, e.data);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) return;
            @(negedge clk);
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    // called at a negedge, returns at the negedge where done is high
    task automatic cmd(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s);
        exp_t e;
        start = 1'b1; op = o; data_in = d; shamt = s;
        @(posedge clk); #1;
        if (o != OP_NOP && o != 3'b111) begin
            e.data = model(o, d, int'(s));
            e.cyc  = cyc + latency(o, int'(s)) - 1;
            sb.push_back(e);
            last_res = e.data;
        end
        @(negedge clk);
        start = 1'b0;
        if (o != OP_NOP && o != 3'b111) wait_done();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = OP_NOP; data_in = '0; shamt = '0;
        last_res = '0;
        repeat (2) @(negedge clk);
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // directed cases, back-to-back through DONE
        cmd(OP_SLL, 32'h0000_0001, 5'd4);
        cmd(OP_SLL, 32'h0000_ABCD, 5'd16);
        cmd(OP_SRA, 32'h8000_0000, 5'd31);
        cmd(OP_SRL, 32'h8000_0000, 5'd31);
        cmd(OP_ROR, 32'h0000_0001, 5'd1);
        cmd(OP_ROL, 32'h8000_0001, 5'd4);
        cmd(OP_SRL, 32'h1234_5678, 5'd0);
        cmd(OP_LOAD, 32'hDEAD_BEEF, 5'd9);

        // result holds while idle, NOP leaves everything alone
        repeat (4) @(negedge clk);
        chk("hold_idle", data_out, 32'hDEAD_BEEF);
        cmd(OP_NOP, 32'h5555_5555, 5'd3);
        chk("nop_hold", data_out, 32'hDEAD_BEEF);
        chk("nop_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

`ifndef FAST_SHIFT_EN
        // start while busy is dropped; exactly one done for the first command
        begin
            exp_t e;
            start = 1'b1; op = OP_SRL; data_in = 32'hF000_0000; shamt = 5'd3;
            @(posedge clk); #1;
            e.data = 32'h1E00_0000; e.cyc = cyc + 3; sb.push_back(e);
            @(negedge clk);
            chk("busy_during_shift", 32'(busy), 32'd1);
            op = OP_SLL; data_in = 32'hFFFF_FFFF; shamt = 5'd8;
            @(negedge clk);
            start = 1'b0;
            wait_done();
            repeat (12) @(negedge clk);
            chk("after_ignored_start", data_out, 32'h1E00_0000);
        end

        // reset mid-shift aborts without a done
        start = 1'b1; op = OP_SLL; data_in = 32'h0000_00FF; shamt = 5'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_data_out", data_out, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
`endif

        // randomized commands with random gaps and occasional NOPs
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  ro;
            logic [4:0]  rs;
            logic [31:0] rd;
            ro = 3'($urandom_range(0, 7));
            rd = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1) * 31) : 5'($urandom_range(0, 31));
            cmd(ro, rd, rs);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
